seg_scan_capture: RTL and testbench
===================================

Name: seg_scan_capture

Overview:
Receive-side counterpart of the multiplexed 4-digit seven-segment display driver. The block samples the scanned anode/segment bus one scan step at a time and decodes each glyph back into a hex nibble. It reassembles the 16-bit displayed value and flags complete frames, value changes and protocol errors. It is used for self-check loops and for bench scoreboarding of display paths.

Parameters:
SEG_LAG, 1, scan steps by which segments trail anodes on the bus (0 or 1); the display driver produces 1
ERR_CNT_W, 8, width of the saturating error counter

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
scan_en  in  1  one-cycle strobe per scan step; inputs are valid and sampled only when high
anodes  in  4  active-high one-hot digit select, synchronous to clk
segments  in  7  active-high {g,f,e,d,c,b,a}
value  out  16  last complete decoded frame
value_valid  out  1  1-cycle pulse when value is updated
value_changed  out  1  1-cycle pulse, coincident with value_valid, when the new value differs from the previous one
err  out  1  1-cycle pulse on a protocol or glyph error
err_cnt  out  ERR_CNT_W  saturating count of err pulses

Behaviour:
- Reset (async, rst_n=0): value=0, value_valid=0, value_changed=0, err=0, err_cnt=0. Also clears the shadow nibbles, the seen[3:0] mask, the anode delay register and the primed flag. Reset takes priority over scan_en.
- Lag alignment:
  - SEG_LAG=0: the segments sampled at a step pair with the anodes sampled at the same step.
  - SEG_LAG=1: a 4-bit anode_d register loads anodes on each scan_en. The segments at step n pair with anode_d, i.e. the anodes from step n-1.
  - With SEG_LAG=1, the first scan_en after reset only loads anode_d (primed<=1). No decode and no error on that step.
- Digit map (fixed, matches driver): anode 4'b1000 -> value[15:12], 4'b0001 -> [11:8], 4'b0010 -> [7:4], 4'b0100 -> [3:0].
- Glyph table: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71. Any other pattern is invalid.
- Per decoded step (scan_en=1 and primed):
  - Paired anode not one-hot (including 0), or glyph invalid: err=1 next cycle, err_cnt+1 saturating at all-ones, seen cleared. Shadow contents are discarded (frame aborted).
  - Otherwise: shadow[digit] <= nibble and seen[digit] <= 1. A repeated digit before frame completion overwrites its shadow with no error.
- Frame completion: if (seen | current digit bit) == 4'b1111 after a valid step, then on the next cycle:
  - value <= the shadow including the current nibble, and value_valid=1.
  - value_changed=1 if the new value != the old value. The first frame after reset compares against 0.
  - seen clears in the same update.
- Latency: 1 clk from the completing scan_en to value_valid. 1 clk from the offending scan_en to err.
- All pulses are exactly one cycle wide, even under back-to-back scan_en. value holds between frames.
- scan_en=0: no state changes except clearing of pulses.

Decomposition:
- Package seg_pkg holds:
  - the 16 glyph localparams (SEG_0..SEG_F);
  - the digit-to-anode localparams (AN_D3=4'b1000, AN_D2=4'b0001, AN_D1=4'b0010, AN_D0=4'b0100).
- Sub-module seg_to_data: purely combinational; 7-bit segments -> 4-bit nibble plus glyph_ok. It is the inverse of the display's digit encoder and can be reused by the benches.

Test Plan:
- SEG_LAG=0, scan 1000/06, 0001/5B, 0010/4F, 0100/66 -> value=16'h1234, value_valid and value_changed pulse 1 cycle after step 4, err=0.
- Repeat the same frame -> value_valid pulses, value_changed=0. Then a frame encoding 16'hBEEF (7C,79,79,71 on the mapped anodes) -> value=16'hBEEF, value_changed=1.
- SEG_LAG=1, driver-style skewed stream starting after reset -> first step ignored, no err; value=16'hFFFF after the first full aligned frame.
- Glyph 7'h00 on step 2 -> err pulse, err_cnt=1, seen cleared, value unchanged. The next clean 4-step frame decodes correctly.
- Anodes 4'b0011, then 4'b0000 -> two err pulses, err_cnt=2. Force 300 errors with ERR_CNT_W=8 -> err_cnt saturates at 255.
- Assert rst_n=0 mid-frame after 3 valid steps -> all outputs 0 immediately. A subsequent 4-step frame completes with no carry-over from the aborted frame.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - glyph codes, digit-to-anode map and step classification for the scan capture
package seg_pkg;

   // Active-high {g,f,e,d,c,b,a} patterns produced by the display driver
   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h7C;
   localparam logic [6:0] SEG_C = 7'h39;
   localparam logic [6:0] SEG_D = 7'h5E;
   localparam logic [6:0] SEG_E = 7'h79;
   localparam logic [6:0] SEG_F = 7'h71;

   // Anode that selects each displayed digit; D3 is the most significant nibble
   localparam logic [3:0] AN_D3 = 4'b1000;
   localparam logic [3:0] AN_D2 = 4'b0001;
   localparam logic [3:0] AN_D1 = 4'b0010;
   localparam logic [3:0] AN_D0 = 4'b0100;

   // What a single sampled scan step does to the capture state
   typedef enum logic [1:0] {
      STEP_NONE,
      STEP_PRIME,
      STEP_ERR,
      STEP_DATA
   } step_e;

   // Nibble position (3 = value[15:12]) for a one-hot anode; only meaningful when one-hot
   function automatic logic [1:0] anode_slot(input logic [3:0] an);
      logic [1:0] slot;
      case (an)
         AN_D3:   slot = 2'd3;
         AN_D2:   slot = 2'd2;
         AN_D1:   slot = 2'd1;
         default: slot = 2'd0;
      endcase
      return slot;
   endfunction

   // True when exactly one anode line is asserted
   function automatic logic anode_onehot(input logic [3:0] an);
      return (an != 4'b0000) && ((an & (an - 4'd1)) == 4'b0000);
   endfunction

endpackage

// File: rtl/seg_scan_capture_if.sv
// rtl/seg_scan_capture_if.sv - scanned anode/segment bus between a display driver and the capture
interface seg_scan_capture_if;
   logic       scan_en;
   logic [3:0] anodes;
   logic [6:0] segments;

   modport master (output scan_en, output anodes, output segments);
   modport slave  (input  scan_en, input  anodes, input  segments);
endinterface

// File: rtl/seg_to_data.sv
// rtl/seg_to_data.sv - combinational seven-segment glyph to hex nibble decoder
module seg_to_data
   import seg_pkg::*;
(
   input  logic [6:0] segments,
   output logic [3:0] nibble,
   output logic       glyph_ok
);

   // Inverse of the display's digit encoder; any pattern outside the table is rejected
   always_comb begin
      nibble   = 4'h0;
      glyph_ok = 1'b1;
      case (segments)
         SEG_0:   nibble = 4'h0;
         SEG_1:   nibble = 4'h1;
         SEG_2:   nibble = 4'h2;
         SEG_3:   nibble = 4'h3;
         SEG_4:   nibble = 4'h4;
         SEG_5:   nibble = 4'h5;
         SEG_6:   nibble = 4'h6;
         SEG_7:   nibble = 4'h7;
         SEG_8:   nibble = 4'h8;
         SEG_9:   nibble = 4'h9;
         SEG_A:   nibble = 4'hA;
         SEG_B:   nibble = 4'hB;
         SEG_C:   nibble = 4'hC;
         SEG_D:   nibble = 4'hD;
         SEG_E:   nibble = 4'hE;
         SEG_F:   nibble = 4'hF;
         default: glyph_ok = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_scan_capture.sv
// rtl/seg_scan_capture.sv - decodes a multiplexed 4-digit seven-segment scan back into a 16-bit value
module seg_scan_capture
   import seg_pkg::*;
#(
   parameter int SEG_LAG   = 1,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   seg_scan_capture_if.slave    scan,
   output logic [15:0]          value,
   output logic                 value_valid,
   output logic                 value_changed,
   output logic                 err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   logic [3:0]  anode_d;
   logic        primed;
   logic [15:0] shadow;
   logic [3:0]  seen;

   logic [3:0]  pair_an;
   logic [3:0]  nibble;
   logic        glyph_ok;
   logic [1:0]  slot;
   logic [3:0]  slot_bit;
   logic [15:0] merged;
   logic        frame_done;
   step_e       step;

   // With a lagging bus the segments belong to the anodes of the previous step
   assign pair_an = (SEG_LAG != 0) ? anode_d : scan.anodes;

   seg_to_data u_seg_to_data (
      .segments (scan.segments),
      .nibble   (nibble),
      .glyph_ok (glyph_ok)
   );

   assign slot     = anode_slot(pair_an);
   assign slot_bit = 4'b0001 << slot;

   // Classify the current step: priming load, aborting error, or a digit to store
   always_comb begin
      step = STEP_NONE;
      if (scan.scan_en) begin
         if ((SEG_LAG != 0) && !primed) begin
            step = STEP_PRIME;
         end else if (!anode_onehot(pair_an) || !glyph_ok) begin
            step = STEP_ERR;
         end else begin
            step = STEP_DATA;
         end
      end
   end

   // Shadow with the current nibble dropped into its slot, and whether that closes the frame
   always_comb begin
      merged = shadow;
      merged[{slot, 2'b00} +: 4] = nibble;
      frame_done = (step == STEP_DATA) && ((seen | slot_bit) == 4'b1111);
   end

   // Anode history: the delay register follows every sampled step, priming on the first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         anode_d <= 4'b0000;
         primed  <= 1'b0;
      end else if (scan.scan_en) begin
         anode_d <= scan.anodes;
         primed  <= 1'b1;
      end
   end

   // Frame assembly, error accounting and one-cycle status pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow        <= 16'h0000;
         seen          <= 4'b0000;
         value         <= 16'h0000;
         value_valid   <= 1'b0;
         value_changed <= 1'b0;
         err           <= 1'b0;
         err_cnt       <= '0;
      end else begin
         value_valid   <= 1'b0;
         value_changed <= 1'b0;
         err           <= 1'b0;
         case (step)
            STEP_ERR: begin
               err    <= 1'b1;
               seen   <= 4'b0000;
               shadow <= 16'h0000;
               if (err_cnt != '1) begin
                  err_cnt <= err_cnt + ERR_CNT_W'(1);
               end
            end
            STEP_DATA: begin
               shadow <= merged;
               if (frame_done) begin
                  seen          <= 4'b0000;
                  value         <= merged;
                  value_valid   <= 1'b1;
                  value_changed <= (merged != value);
               end else begin
                  seen <= seen | slot_bit;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb/tb_seg_scan_capture.sv - self-checking bench for seg_scan_capture with lag 0 and lag 1 instances
module tb_seg_scan_capture;
   import seg_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   seg_scan_capture_if bus0 ();
   seg_scan_capture_if bus1 ();

   logic [15:0] val_o [2];
   logic        vv_o  [2];
   logic        vc_o  [2];
   logic        er_o  [2];
   logic [7:0]  cnt_o [2];

   seg_scan_capture #(.SEG_LAG(0), .ERR_CNT_W(8)) dut0 (
      .clk (clk), .rst_n (rst_n), .scan (bus0),
      .value (val_o[0]), .value_valid (vv_o[0]), .value_changed (vc_o[0]),
      .err (er_o[0]), .err_cnt (cnt_o[0])
   );

   seg_scan_capture #(.SEG_LAG(1), .ERR_CNT_W(8)) dut1 (
      .clk (clk), .rst_n (rst_n), .scan (bus1),
      .value (val_o[1]), .value_valid (vv_o[1]), .value_changed (vc_o[1]),
      .err (er_o[1]), .err_cnt (cnt_o[1])
   );

   localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   // Anode that drives nibble position p (p = 0 is value[3:0])
   localparam logic [3:0] POS_AN [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
   localparam int LAG [2] = '{0, 1};
   localparam int CNT_MAX = 255;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state, one set per instance
   logic [15:0] m_val  [2];
   int          m_cnt  [2];
   logic [3:0]  m_nib  [2][4];
   bit          m_seen [2][4];
   logic [3:0]  m_prev [2];
   bit          m_primed [2];
   bit          e_valid [2];
   bit          e_chg   [2];
   bit          e_err   [2];

   typedef struct {
      logic [3:0]  an;
      logic [6:0]  seg;
      bit          ev;
      bit          ec;
      bit          ee;
      logic [15:0] evalue;
      int          ecnt;
   } vec_t;
   vec_t vecs [$];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_val[d] = 16'h0; m_cnt[d] = 0; m_prev[d] = 4'h0; m_primed[d] = 0;
         e_valid[d] = 0; e_chg[d] = 0; e_err[d] = 0;
         for (int p = 0; p < 4; p++) begin
            m_nib[d][p] = 4'h0; m_seen[d][p] = 0;
         end
      end
   endtask

   task automatic model_step(int d, bit en, logic [3:0] an, logic [6:0] seg);
      logic [3:0]  pair;
      logic [15:0] newv;
      int          g;
      int          p;
      bit          all;
      e_valid[d] = 0; e_chg[d] = 0; e_err[d] = 0;
      if (!en) return;
      if (LAG[d] != 0 && !m_primed[d]) begin
         m_primed[d] = 1;
         m_prev[d] = an;
         return;
      end
      pair = (LAG[d] != 0) ? m_prev[d] : an;
      m_prev[d] = an;
      g = -1;
      for (int k = 0; k < 16; k++) if (GLYPH[k] == seg) g = k;
      p = -1;
      for (int q = 0; q < 4; q++) if (POS_AN[q] == pair) p = q;
      if (g < 0 || p < 0) begin
         e_err[d] = 1;
         if (m_cnt[d] < CNT_MAX) m_cnt[d]++;
         for (int q = 0; q < 4; q++) m_seen[d][q] = 0;
      end else begin
         m_nib[d][p] = 4'(g);
         m_seen[d][p] = 1;
         all = m_seen[d][0] && m_seen[d][1] && m_seen[d][2] && m_seen[d][3];
         if (all) begin
            newv = {m_nib[d][3], m_nib[d][2], m_nib[d][1], m_nib[d][0]};
            e_valid[d] = 1;
            e_chg[d] = (newv != m_val[d]);
            m_val[d] = newv;
            for (int q = 0; q < 4; q++) m_seen[d][q] = 0;
         end
      end
   endtask

   task automatic compare_all(string tag);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("%s.d%0d.value", tag, d), 32'(val_o[d]), 32'(m_val[d]));
         check($sformatf("%s.d%0d.value_valid", tag, d), 32'(vv_o[d]), 32'(e_valid[d]));
         check($sformatf("%s.d%0d.value_changed", tag, d), 32'(vc_o[d]), 32'(e_chg[d]));
         check($sformatf("%s.d%0d.err", tag, d), 32'(er_o[d]), 32'(e_err[d]));
         check($sformatf("%s.d%0d.err_cnt", tag, d), 32'(cnt_o[d]), 32'(m_cnt[d]));
      end
   endtask

   // One clock: drive instance d (the other idles), advance the model, compare at the falling edge
   task automatic cycle(int d, bit en, logic [3:0] an, logic [6:0] seg, string tag);
      if (d == 0) begin
         bus0.scan_en = en; bus0.anodes = an; bus0.segments = seg; bus1.scan_en = 1'b0;
      end else begin
         bus1.scan_en = en; bus1.anodes = an; bus1.segments = seg; bus0.scan_en = 1'b0;
      end
      model_step(d, en, an, seg);
      model_step(1 - d, 1'b0, 4'h0, 7'h00);
      @(posedge clk);
      @(negedge clk);
      compare_all(tag);
   endtask

   task automatic add(logic [3:0] an, logic [6:0] seg, bit ev, bit ec, bit ee,
                      logic [15:0] evalue, int ecnt);
      vec_t v;
      v.an = an; v.seg = seg; v.ev = ev; v.ec = ec; v.ee = ee; v.evalue = evalue; v.ecnt = ecnt;
      vecs.push_back(v);
   endtask

   initial begin
      add(4'b1000, 7'h06, 0, 0, 0, 16'h0000, 0);
      add(4'b0001, 7'h5B, 0, 0, 0, 16'h0000, 0);
      add(4'b0010, 7'h4F, 0, 0, 0, 16'h0000, 0);
      add(4'b0100, 7'h66, 1, 1, 0, 16'h1234, 0);
      add(4'b1000, 7'h06, 0, 0, 0, 16'h1234, 0);
      add(4'b0001, 7'h5B, 0, 0, 0, 16'h1234, 0);
      add(4'b0010, 7'h4F, 0, 0, 0, 16'h1234, 0);
      add(4'b0100, 7'h66, 1, 0, 0, 16'h1234, 0);
      add(4'b1000, 7'h7C, 0, 0, 0, 16'h1234, 0);
      add(4'b0001, 7'h79, 0, 0, 0, 16'h1234, 0);
      add(4'b0010, 7'h79, 0, 0, 0, 16'h1234, 0);
      add(4'b0100, 7'h71, 1, 1, 0, 16'hBEEF, 0);
      add(4'b1000, 7'h06, 0, 0, 0, 16'hBEEF, 0);
      add(4'b0001, 7'h00, 0, 0, 1, 16'hBEEF, 1);
      add(4'b1000, 7'h3F, 0, 0, 0, 16'hBEEF, 1);
      add(4'b0001, 7'h77, 0, 0, 0, 16'hBEEF, 1);
      add(4'b0010, 7'h6D, 0, 0, 0, 16'hBEEF, 1);
      add(4'b0100, 7'h39, 1, 1, 0, 16'h0A5C, 1);
      add(4'b1000, 7'h06, 0, 0, 0, 16'h0A5C, 1);
      add(4'b0011, 7'h06, 0, 0, 1, 16'h0A5C, 2);
      add(4'b0000, 7'h06, 0, 0, 1, 16'h0A5C, 3);
      add(4'b0001, 7'h5B, 0, 0, 0, 16'h0A5C, 3);
      add(4'b0010, 7'h5B, 0, 0, 0, 16'h0A5C, 3);
      add(4'b0100, 7'h5B, 0, 0, 0, 16'h0A5C, 3);
      add(4'b1000, 7'h4F, 1, 1, 0, 16'h3222, 3);

      bus0.scan_en = 1'b0; bus0.anodes = 4'h0; bus0.segments = 7'h00;
      bus1.scan_en = 1'b0; bus1.anodes = 4'h0; bus1.segments = 7'h00;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      compare_all("reset");
      rst_n = 1'b1;

      // Directed lag-0 vectors
      for (int i = 0; i < vecs.size(); i++) begin
         cycle(0, 1'b1, vecs[i].an, vecs[i].seg, $sformatf("vec%0d", i));
         check($sformatf("vec%0d.value", i), 32'(val_o[0]), 32'(vecs[i].evalue));
         check($sformatf("vec%0d.valid", i), 32'(vv_o[0]), 32'(vecs[i].ev));
         check($sformatf("vec%0d.changed", i), 32'(vc_o[0]), 32'(vecs[i].ec));
         check($sformatf("vec%0d.err", i), 32'(er_o[0]), 32'(vecs[i].ee));
         check($sformatf("vec%0d.err_cnt", i), 32'(cnt_o[0]), 32'(vecs[i].ecnt));
      end
      for (int i = 0; i < 3; i++) cycle(0, 1'b0, 4'b1111, 7'h00, "idle0");

      // Lag-1 driver-style skewed stream: first step only primes
      cycle(1, 1'b1, 4'b1000, 7'h00, "lag_prime");
      check("lag_prime.err", 32'(er_o[1]), 32'd0);
      cycle(1, 1'b1, 4'b0001, 7'h71, "lag1");
      cycle(1, 1'b1, 4'b0010, 7'h71, "lag2");
      cycle(1, 1'b1, 4'b0100, 7'h71, "lag3");
      cycle(1, 1'b1, 4'b1000, 7'h71, "lag4");
      check("lag_frame.value", 32'(val_o[1]), 32'h0000FFFF);
      check("lag_frame.valid", 32'(vv_o[1]), 32'd1);
      check("lag_frame.changed", 32'(vc_o[1]), 32'd1);
      cycle(1, 1'b0, 4'b0000, 7'h00, "lag_idle");
      check("lag_idle.valid", 32'(vv_o[1]), 32'd0);

      // Error counter saturation under back-to-back bad anodes
      for (int i = 0; i < 300; i++) cycle(0, 1'b1, 4'b0011, 7'h06, "sat");
      check("sat.err_cnt", 32'(cnt_o[0]), 32'd255);
      cycle(0, 1'b0, 4'b0000, 7'h00, "sat_idle");
      check("sat_idle.err", 32'(er_o[0]), 32'd0);

      // Asynchronous reset in the middle of a frame
      cycle(0, 1'b1, 4'b1000, 7'h06, "mid1");
      cycle(0, 1'b1, 4'b0001, 7'h06, "mid2");
      cycle(0, 1'b1, 4'b0010, 7'h06, "mid3");
      rst_n = 1'b0;
      #1;
      model_reset();
      check("async_rst.value", 32'(val_o[0]), 32'd0);
      check("async_rst.err_cnt", 32'(cnt_o[0]), 32'd0);
      check("async_rst.lag_value", 32'(val_o[1]), 32'd0);
      @(negedge clk);
      compare_all("in_reset");
      rst_n = 1'b1;
      cycle(0, 1'b1, 4'b0100, 7'h5B, "post1");
      check("post1.no_carry", 32'(vv_o[0]), 32'd0);
      cycle(0, 1'b1, 4'b1000, 7'h4F, "post2");
      cycle(0, 1'b1, 4'b0001, 7'h66, "post3");
      cycle(0, 1'b1, 4'b0010, 7'h6D, "post4");
      check("post_frame.value", 32'(val_o[0]), 32'h00003452);

      // Randomized traffic on both instances against the model
      for (int i = 0; i < 1500; i++) begin
         int          d;
         bit          en;
         logic [3:0]  an;
         logic [6:0]  seg;
         d  = int'($urandom_range(0, 1));
         en = ($urandom_range(0, 3) != 0);
         an = ($urandom_range(0, 9) < 8) ? POS_AN[$urandom_range(0, 3)] : 4'($urandom);
         seg = ($urandom_range(0, 19) < 17) ? GLYPH[$urandom_range(0, 15)] : 7'($urandom);
         cycle(d, en, an, seg, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
